// File: rtl/shift_pkg.sv
// Shared types and default widths for the sequential left shifter.
package shift_pkg;
    localparam int N_DEF  = 4;
    localparam int AW_DEF = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } shift_state_t;
endpackage

// File: rtl/shift_left_seq_if.sv
// Start/result handshake bundle for shift_left_seq; master drives requests, slave is the shifter.
interface shift_left_seq_if
    import shift_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
);
    logic          start;
    logic [N-1:0]  data_in;
    logic [AW-1:0] amount;
    logic          ready;
    logic [N-1:0]  data_out;
    logic          carry;
    logic          zero;
    logic          done;

    modport master (
        output start, data_in, amount,
        input  ready, data_out, carry, zero, done
    );

    modport slave (
        input  start, data_in, amount,
        output ready, data_out, carry, zero, done
    );
endinterface

// File: rtl/shift_cnt.sv
// Loadable down counter tracking the remaining single-bit shifts.
module shift_cnt #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          dec,
    input  logic [AW-1:0] load_val,
    output logic          is_one
);
    logic [AW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign is_one = (count_reg == AW'(1));
endmodule

// File: rtl/shift_left_seq.sv
// Multi-cycle left shifter, one bit per clock with carry-out and done pulse.
// Define SHIFT_LEFT_ROTATE_EN to rotate (MSB refills bit 0) instead of zero-filling.
module shift_left_seq
    import shift_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int AW = AW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    shift_left_seq_if.slave  bus
);
    shift_state_t  state_reg, state_next;
    logic [N-1:0]  data_reg, data_next;
    logic          carry_reg, carry_next;
    logic [N-1:0]  shifted;
    logic          fill_bit;
    logic          cnt_load, cnt_dec, cnt_is_one;

`ifdef SHIFT_LEFT_ROTATE_EN
    assign fill_bit = data_reg[N-1];
`else
    assign fill_bit = 1'b0;
`endif

    assign shifted[0] = fill_bit;
    for (genvar gi = 1; gi < N; gi++) begin : g_shift
        assign shifted[gi] = data_reg[gi-1];
    end

    shift_cnt #(.AW(AW)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (bus.amount),
        .is_one   (cnt_is_one)
    );

    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        carry_next = carry_reg;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    data_next  = bus.data_in;
                    carry_next = 1'b0;
                    cnt_load   = 1'b1;
                    state_next = (bus.amount != '0) ? SHIFT : DONE;
                end
            end
            SHIFT: begin
                carry_next = data_reg[N-1];
                data_next  = shifted;
                cnt_dec    = 1'b1;
                // Counter still holds the pre-decrement value: 1 means this is the last step.
                if (cnt_is_one) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            carry_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            carry_reg <= carry_next;
        end
    end

    assign bus.ready    = (state_reg == IDLE);
    assign bus.done     = (state_reg == DONE);
    assign bus.zero     = (state_reg == DONE) && (data_reg == '0);
    assign bus.data_out = data_reg;
    assign bus.carry    = carry_reg;
endmodule
